// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Brief   : Shared op encodings, FSM states and flag bit positions.
// Rev     : 1.0
// ============================================================================
package alu_pkg;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_ADD   = 3'd1;
    localparam logic [2:0] OP_SUB   = 3'd2;
    localparam logic [2:0] OP_AND   = 3'd3;
    localparam logic [2:0] OP_OR    = 3'd4;
    localparam logic [2:0] OP_XOR   = 3'd5;
    localparam logic [2:0] OP_CMP   = 3'd6;
    localparam logic [2:0] OP_SHIFT = 3'd7;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_issue_ctrl_regfile.sv
`default_nettype none
// ============================================================================
// Module  : regfile
// Brief   : NREGS x WIDTH register file, two read ports plus debug, r0 = 0.
// Rev     : 1.0
// ============================================================================
module regfile #(
    parameter int WIDTH  = 32,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddrA_i,
    input  logic [ADDR_W-1:0] raddrB_i,
    input  logic [ADDR_W-1:0] raddrD_i,
    output logic [WIDTH-1:0]  rdataA_o,
    output logic [WIDTH-1:0]  rdataB_o,
    output logic [WIDTH-1:0]  rdataD_o
);

    logic [WIDTH-1:0] mem_q [NREGS];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Entry 0 is never written, but the read mux forces zero regardless.
    assign rdataA_o = (raddrA_i == '0) ? '0 : mem_q[raddrA_i];
    assign rdataB_o = (raddrB_i == '0) ? '0 : mem_q[raddrB_i];
    assign rdataD_o = (raddrD_i == '0) ? '0 : mem_q[raddrD_i];

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : alu_issue_ctrl
// Brief   : Single-issue operand fetch / writeback controller around the ALU.
// Rev     : 1.0
// ============================================================================
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instrValid,
    output logic              instrReady,
    input  logic [2:0]        instrOp,
    input  logic [ADDR_W-1:0] instrRd,
    input  logic [ADDR_W-1:0] instrRs,
    input  logic [ADDR_W-1:0] instrRt,
    input  logic              extWrEn,
    input  logic [ADDR_W-1:0] extWrAddr,
    input  logic [WIDTH-1:0]  extWrData,
    output logic [WIDTH-1:0]  busA,
    output logic [WIDTH-1:0]  busB,
    output logic [2:0]        control,
    input  logic [WIDTH-1:0]  aluDataOut,
    input  logic              aluZero,
    input  logic              aluOverflow,
    input  logic              aluCarryout,
    input  logic              aluNegative,
    output logic [3:0]        flags,
    output logic              done,
    input  logic [ADDR_W-1:0] dbgAddr,
    output logic [WIDTH-1:0]  dbgData
);

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [3:0]        shadow_q, shadow_d;
    logic [3:0]        flags_q, flags_d;
    logic [WIDTH-1:0]  busA_q, busA_d;
    logic [WIDTH-1:0]  busB_q, busB_d;
    logic [2:0]        control_q, control_d;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [WIDTH-1:0]  rf_wdata;
    logic [WIDTH-1:0]  rf_rdA, rf_rdB;

    regfile #(
        .WIDTH  (WIDTH),
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clock    (clock),
        .reset    (reset),
        .we_i     (rf_we),
        .waddr_i  (rf_waddr),
        .wdata_i  (rf_wdata),
        .raddrA_i (instrRs),
        .raddrB_i (instrRt),
        .raddrD_i (dbgAddr),
        .rdataA_o (rf_rdA),
        .rdataB_o (rf_rdB),
        .rdataD_o (dbgData)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rd_d       = rd_q;
        result_d   = result_q;
        shadow_d   = shadow_q;
        flags_d    = flags_q;
        busA_d     = '0;
        busB_d     = '0;
        control_d  = '0;
        rf_we      = 1'b0;
        rf_waddr   = extWrAddr;
        rf_wdata   = extWrData;
        done       = 1'b0;
        instrReady = 1'b0;

        case (state_q)
            ST_IDLE: begin
                instrReady = !extWrEn && !reset;
                // External load takes priority and blocks issue for this cycle.
                if (extWrEn) begin
                    rf_we = 1'b1;
                end else if (instrValid) begin
                    op_d      = instrOp;
                    rd_d      = instrRd;
                    busA_d    = rf_rdA;
                    busB_d    = rf_rdB;
                    control_d = instrOp;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d         = aluDataOut;
                shadow_d[FLAG_N] = aluNegative;
                shadow_d[FLAG_Z] = aluZero;
                shadow_d[FLAG_C] = aluCarryout;
                shadow_d[FLAG_V] = aluOverflow;
                state_d          = ST_WB;
            end
            ST_WB: begin
                done = 1'b1;
                if (op_q != OP_NOP) begin
                    rf_we    = 1'b1;
                    rf_waddr = rd_q;
                    rf_wdata = result_q;
                    flags_d  = shadow_q;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            rd_q      <= '0;
            result_q  <= '0;
            shadow_q  <= '0;
            flags_q   <= '0;
            busA_q    <= '0;
            busB_q    <= '0;
            control_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            result_q  <= result_d;
            shadow_q  <= shadow_d;
            flags_q   <= flags_d;
            busA_q    <= busA_d;
            busB_q    <= busB_d;
            control_q <= control_d;
        end
    end

    assign busA    = busA_q;
    assign busB    = busB_q;
    assign control = control_q;
    assign flags   = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_issue_ctrl
// Brief   : Directed self-checking bench with a combinational stub ALU.
// Rev     : 1.0
// ============================================================================
module tb_alu_issue_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        instrValid;
    logic        instrReady;
    logic [2:0]  instrOp;
    logic [4:0]  instrRd, instrRs, instrRt;
    logic        extWrEn;
    logic [4:0]  extWrAddr;
    logic [31:0] extWrData;
    logic [31:0] busA, busB;
    logic [2:0]  control;
    logic [31:0] aluDataOut;
    logic        aluZero, aluOverflow, aluCarryout, aluNegative;
    logic [3:0]  flags;
    logic        done;
    logic [4:0]  dbgAddr;
    logic [31:0] dbgData;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    alu_issue_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .instrValid  (instrValid),
        .instrReady  (instrReady),
        .instrOp     (instrOp),
        .instrRd     (instrRd),
        .instrRs     (instrRs),
        .instrRt     (instrRt),
        .extWrEn     (extWrEn),
        .extWrAddr   (extWrAddr),
        .extWrData   (extWrData),
        .busA        (busA),
        .busB        (busB),
        .control     (control),
        .aluDataOut  (aluDataOut),
        .aluZero     (aluZero),
        .aluOverflow (aluOverflow),
        .aluCarryout (aluCarryout),
        .aluNegative (aluNegative),
        .flags       (flags),
        .done        (done),
        .dbgAddr     (dbgAddr),
        .dbgData     (dbgData)
    );

    // Stub ALU: carry on SUB/CMP means borrow.
    logic [32:0] w_sum, w_diff;
    always_comb begin
        w_sum       = {1'b0, busA} + {1'b0, busB};
        w_diff      = {1'b0, busA} - {1'b0, busB};
        aluDataOut  = '0;
        aluCarryout = 1'b0;
        aluOverflow = 1'b0;
        case (control)
            3'd1: begin
                aluDataOut  = w_sum[31:0];
                aluCarryout = w_sum[32];
                aluOverflow = (busA[31] == busB[31]) && (w_sum[31] != busA[31]);
            end
            3'd2, 3'd6: begin
                aluDataOut  = w_diff[31:0];
                aluCarryout = w_diff[32];
                aluOverflow = (busA[31] != busB[31]) && (w_diff[31] != busA[31]);
            end
            3'd3:    aluDataOut = busA & busB;
            3'd4:    aluDataOut = busA | busB;
            3'd5:    aluDataOut = busA ^ busB;
            3'd7:    aluDataOut = busA << busB[4:0];
            default: aluDataOut = '0;
        endcase
        aluZero     = (aluDataOut == '0);
        aluNegative = aluDataOut[31];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic rd_dbg(input string tag, input logic [4:0] a, input logic [31:0] exp);
        dbgAddr = a;
        #1;
        check(tag, dbgData, exp);
    endtask

    task automatic ext_load(input logic [4:0] a, input logic [31:0] d);
        extWrEn   = 1'b1;
        extWrAddr = a;
        extWrData = d;
        #1;
        check("ready_low_during_extwr", {31'd0, instrReady}, 32'd0);
        step();
        extWrEn = 1'b0;
    endtask

    // Accept at edge k, EXEC after it, WB (done) after k+1, IDLE after k+2.
    task automatic issue(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [31:0] expA, input logic [31:0] expB);
        instrValid = 1'b1;
        instrOp    = op;
        instrRd    = rd;
        instrRs    = rs;
        instrRt    = rt;
        #1;
        check("ready_idle", {31'd0, instrReady}, 32'd1);
        step();
        instrValid = 1'b0;
        check("exec_busA", busA, expA);
        check("exec_busB", busB, expB);
        check("exec_control", {29'd0, control}, {29'd0, op});
        check("exec_done", {31'd0, done}, 32'd0);
        step();
        check("wb_done", {31'd0, done}, 32'd1);
        check("wb_busA_clr", busA, 32'd0);
        step();
        check("idle_done", {31'd0, done}, 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        instrValid = 1'b0;
        instrOp    = '0;
        instrRd    = '0;
        instrRs    = '0;
        instrRt    = '0;
        extWrEn    = 1'b0;
        extWrAddr  = '0;
        extWrData  = '0;
        dbgAddr    = '0;
        step();
        check("rst_ready", {31'd0, instrReady}, 32'd0);
        check("rst_busA", busA, 32'd0);
        check("rst_flags", {28'd0, flags}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        #1;
        check("ready_after_rst", {31'd0, instrReady}, 32'd1);

        // ADD 5 + 3
        ext_load(5'd1, 32'd5);
        ext_load(5'd2, 32'd3);
        rd_dbg("dbg_r1", 5'd1, 32'd5);
        issue(3'd1, 5'd3, 5'd1, 5'd2, 32'd5, 32'd3);
        rd_dbg("add_r3", 5'd3, 32'd8);
        check("add_flags", {28'd0, flags}, 32'h0);

        // Signed overflow into the sign bit
        ext_load(5'd1, 32'h7FFF_FFFF);
        ext_load(5'd2, 32'd1);
        issue(3'd1, 5'd4, 5'd1, 5'd2, 32'h7FFF_FFFF, 32'd1);
        rd_dbg("ovf_r4", 5'd4, 32'h8000_0000);
        check("ovf_flags", {28'd0, flags}, 32'h9);

        // NOP: no writeback, flags held
        issue(3'd0, 5'd5, 5'd1, 5'd2, 32'h7FFF_FFFF, 32'd1);
        rd_dbg("nop_r5", 5'd5, 32'd0);
        check("nop_flags", {28'd0, flags}, 32'h9);

        // SUB into r0, rs == rt
        issue(3'd2, 5'd0, 5'd1, 5'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        rd_dbg("sub_r0", 5'd0, 32'd0);
        check("sub_flags", {28'd0, flags}, 32'h4);

        // Valid held across two instructions, ext write during EXEC ignored
        instrValid = 1'b1;
        instrOp    = 3'd1;
        instrRd    = 5'd6;
        instrRs    = 5'd1;
        instrRt    = 5'd2;
        step();
        instrOp   = 3'd3;
        instrRd   = 5'd7;
        instrRs   = 5'd2;
        instrRt   = 5'd2;
        extWrEn   = 1'b1;
        extWrAddr = 5'd7;
        extWrData = 32'hDEAD_BEEF;
        #1;
        check("q_ready_exec", {31'd0, instrReady}, 32'd0);
        step();
        extWrEn = 1'b0;
        check("q_ready_wb", {31'd0, instrReady}, 32'd0);
        check("q_done_wb", {31'd0, done}, 32'd1);
        step();
        check("q_ready_idle", {31'd0, instrReady}, 32'd1);
        rd_dbg("q_extwr_ignored", 5'd7, 32'd0);
        rd_dbg("q_r6", 5'd6, 32'h8000_0000);
        step();
        instrValid = 1'b0;
        check("q_second_ctrl", {29'd0, control}, 32'd3);
        check("q_second_busA", busA, 32'd1);
        step();
        step();
        rd_dbg("q_r7", 5'd7, 32'd1);
        check("q_flags", {28'd0, flags}, 32'h0);

        // Reset during EXEC aborts the instruction
        issue(3'd2, 5'd0, 5'd1, 5'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        check("pre_rst_flags", {28'd0, flags}, 32'h4);
        instrValid = 1'b1;
        instrOp    = 3'd1;
        instrRd    = 5'd3;
        instrRs    = 5'd1;
        instrRt    = 5'd2;
        step();
        instrValid = 1'b0;
        check("pre_rst_busA", busA, 32'h7FFF_FFFF);
        reset = 1'b1;
        #1;
        check("arst_busA", busA, 32'd0);
        check("arst_busB", busB, 32'd0);
        check("arst_control", {29'd0, control}, 32'd0);
        check("arst_flags", {28'd0, flags}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_ready", {31'd0, instrReady}, 32'd0);
        step();
        reset = 1'b0;
        #1;
        check("post_rst_ready", {31'd0, instrReady}, 32'd1);
        step();
        check("post_rst_done", {31'd0, done}, 32'd0);
        rd_dbg("post_rst_r3", 5'd3, 32'd0);
        check("post_rst_flags", {28'd0, flags}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Single-issue operand-fetch and writeback controller that sits directly upstream and downstream of the 32-bit ALU.
- Accepts one ALU instruction at a time (op, rd, rs, rt) over a valid/ready handshake and reads operands from an internal 32x32 register file.
- Drives busA, busB and control to the ALU, captures dataOut and the four flags, then writes the result back.
- Also provides an external register-load port and a debug read port for bring-up and test.

Parameters:
- WIDTH, 32, datapath width; must match the ALU bus width.
- NREGS, 32, number of architectural registers.
- ADDR_W, 5, register index width; equals log2(NREGS).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- instrValid  in  1  instruction present.
- instrReady  out  1  controller can accept an instruction.
- instrOp  in  3  ALU op: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 CMP, 7 SHIFT.
- instrRd  in  ADDR_W  destination register.
- instrRs  in  ADDR_W  source register for busA.
- instrRt  in  ADDR_W  source register for busB.
- extWrEn  in  1  external register write request.
- extWrAddr  in  ADDR_W  external write address.
- extWrData  in  WIDTH  external write data.
- busA  out  WIDTH  operand A to the ALU (registered).
- busB  out  WIDTH  operand B to the ALU (registered).
- control  out  3  ALU op select (registered).
- aluDataOut  in  WIDTH  ALU result.
- aluZero, aluOverflow, aluCarryout, aluNegative  in  1 each  ALU flags.
- flags  out  4  sticky flags {N,Z,C,V}, bit3 = N.
- done  out  1  one-cycle pulse when an instruction retires.
- dbgAddr  in  ADDR_W  debug read address.
- dbgData  out  WIDTH  combinational value of rf[dbgAddr].

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE.
  - busA, busB, control, flags, done all = 0; instrReady = 0 while reset is asserted.
  - All registers cleared to 0.
  - An in-flight instruction is aborted with no writeback and no flag update.
- Register 0 always reads 0; writes to register 0 are dropped.
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - instrReady = !extWrEn.
  - If extWrEn is high: write rf[extWrAddr] <= extWrData at the clock edge. No instruction is accepted that cycle.
  - Else if instrValid is high: latch op and rd; load busA <= rf[rs], busB <= rf[rt], control <= op; go to EXEC.
  - busA, busB and control are 0 while in IDLE.
- EXEC (one cycle):
  - ALU is combinational, so its outputs are valid this cycle.
  - At the clock edge, capture aluDataOut into resultReg and the flags into flagShadow.
  - Clear busA, busB and control to 0; go to WB.
- WB (one cycle):
  - done = 1.
  - If op != NOP and rd != 0: rf[rd] <= resultReg.
  - If op != NOP: flags <= flagShadow; otherwise flags are held.
  - Go to IDLE.
- Latency: instruction accepted at edge k; EXEC occupies cycle k+1; done is high in cycle k+2; instrReady can reassert in cycle k+3. Throughput is one instruction per 3 cycles.
- Hazards: none. Writeback completes before the next accept, so a back-to-back read of rd returns the new value without bypass logic.
- Handshake: instrReady is low outside IDLE. Valid may stay high across multiple cycles; exactly one instruction is consumed per valid&&ready edge.
- extWrEn outside IDLE is ignored; it does not write and is not queued.
- rs == rt is legal: both buses carry the same value.
- rd == rs is legal: the old value is read, the new value is written in WB.
- dbgData is combinational and reflects writes starting the cycle after the write edge.

Decomposition:
- Shared package alu_pkg:
  - Op encoding constants OP_NOP..OP_SHIFT (0..7).
  - FSM state encoding.
  - Flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module regfile:
  - NREGS x WIDTH storage with two asynchronous read ports plus the debug read port.
  - One synchronous write port; asynchronous reset clears storage; register 0 hardwired to 0.
  - The controller muxes the write port between the WB writeback and the external write.

Test Plan:
- Ext-load r1=5, r2=3; ADD rd=3 rs=1 rt=2 with a stub ALU returning a+b → busA=5, busB=3, control=1 in the EXEC cycle; done two cycles after accept; rf[3]=8; flags=0000.
- Ext-load r1=0x7FFFFFFF, r2=1; ADD rd=4 with a stub asserting V and N → rf[4]=0x80000000; flags=1001.
- NOP rd=5 after the previous test → done pulses; rf[5] unchanged (0); flags still 1001.
- SUB rd=0 rs=1 rt=1 with stub Z=1 → rf[0] reads 0; flags=0100.
- Hold instrValid high with two queued instructions; assert extWrEn during EXEC → extWrEn ignored; instrReady low for 2 cycles; second instruction accepted at the 3rd edge after the first.
- Assert reset during EXEC → busA, busB, control, flags, done = 0 immediately; no writeback; state IDLE; instrReady=1 one cycle after reset deasserts.
